// File: rtl/axil_reg_master_pkg.sv
// ============================================================================
// Module      : axil_master_pkg
// Description : Shared types and constants for the AXI4-Lite register master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axil_master_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        WR_B = 3'd2,
        RD   = 3'd3,
        RD_R = 3'd4,
        RSP  = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_EXOKAY  = 2'b01;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;
    localparam logic [1:0] RESP_DECERR  = 2'b11;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

`default_nettype wire

// File: rtl/axil_reg_master_if.sv
// ============================================================================
// Module      : axil_reg_master_if
// Description : AXI4-Lite channel bundle with master and slave views.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axil_reg_master_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid, input  awready,
        output wdata, wstrb, wvalid,    input  wready,
        input  bresp, bvalid,           output bready,
        output araddr, arprot, arvalid, input  arready,
        input  rdata, rresp, rvalid,    output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid,    output wready,
        output bresp, bvalid,           input  bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid,    input  rready
    );

endinterface

`default_nettype wire

// File: rtl/axil_reg_master_timeout_cnt.sv
// ============================================================================
// Module      : axil_timeout_cnt
// Description : Per-transaction bus-phase watchdog; TIMEOUT_CYCLES=0 disables.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axil_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  wire  clk,
    input  wire  rst,
    input  wire  clear,
    input  wire  enable,
    output logic expired
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_disabled
            assign expired = 1'b0;
        end else begin : g_enabled
            localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [CW-1:0] c_LAST = CW'(TIMEOUT_CYCLES - 1);
            localparam logic [CW-1:0] c_MAX  = CW'(TIMEOUT_CYCLES);

            logic [CW-1:0] r_cnt;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (clear) begin
                    r_cnt <= '0;
                end else if (enable && (r_cnt != c_MAX)) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            // Flagged in the cycle whose increment reaches TIMEOUT_CYCLES, so a
            // valid is held for exactly TIMEOUT_CYCLES cycles before the abort.
            // Saturation keeps it flagged if a handshake deferred the abort.
            assign expired = enable && (r_cnt >= c_LAST);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/axil_reg_master.sv
// ============================================================================
// Module      : axil_reg_master
// Description : Command/response to single AXI4-Lite read/write initiator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axil_reg_master
    import axil_master_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 16,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  wire                       m_axi_clk,
    input  wire                       m_axi_rst,

    input  wire                       cmd_valid,
    output logic                      cmd_ready,
    input  wire                       cmd_write,
    input  wire  [AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  wire  [AXI_DATA_WIDTH-1:0] cmd_wdata,
    input  wire  [AXI_STRB_WIDTH-1:0] cmd_wstrb,

    output logic                      rsp_valid,
    input  wire                       rsp_ready,
    output logic [AXI_DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      rsp_timeout,

    axil_reg_master_if.master         m_axil
);

    state_t                    r_state;
    logic                      r_awvalid;
    logic                      r_wvalid;
    logic                      r_arvalid;
    logic                      r_bready;
    logic [AXI_ADDR_WIDTH-1:0] r_awaddr;
    logic [AXI_ADDR_WIDTH-1:0] r_araddr;
    logic [AXI_DATA_WIDTH-1:0] r_wdata;
    logic [AXI_STRB_WIDTH-1:0] r_wstrb;

    logic w_accept;
    logic w_bus_active;
    logic w_expired;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_wr_done;
    logic w_abort;

    assign cmd_ready    = (r_state == IDLE);
    assign w_accept     = cmd_ready && cmd_valid;
    assign w_bus_active = (r_state == WR) || (r_state == WR_B) ||
                          (r_state == RD) || (r_state == RD_R);

    assign w_aw_hs   = r_awvalid && m_axil.awready;
    assign w_w_hs    = r_wvalid  && m_axil.wready;
    assign w_wr_done = (!r_awvalid || w_aw_hs) && (!r_wvalid || w_w_hs);

    axil_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (m_axi_clk),
        .rst     (m_axi_rst),
        .clear   (w_accept),
        .enable  (w_bus_active),
        .expired (w_expired)
    );

    // A handshake landing in the expiry cycle takes priority over the abort.
    always_comb begin
        w_abort = 1'b0;
        case (r_state)
            WR:      w_abort = w_expired && !w_aw_hs && !w_w_hs;
            WR_B:    w_abort = w_expired && !m_axil.bvalid;
            RD:      w_abort = w_expired && !m_axil.arready;
            RD_R:    w_abort = w_expired && !m_axil.rvalid;
            default: w_abort = 1'b0;
        endcase
    end

    always_ff @(posedge m_axi_clk or posedge m_axi_rst) begin
        if (m_axi_rst) begin
            r_state     <= IDLE;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_bready    <= 1'b1;
            r_awaddr    <= '0;
            r_araddr    <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_resp    <= RESP_OKAY;
            rsp_timeout <= 1'b0;
        end else if (w_abort) begin
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_bready    <= 1'b1;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_resp    <= RESP_SLVERR;
            rsp_timeout <= 1'b1;
            r_state     <= RSP;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        rsp_timeout <= 1'b0;
                        if (cmd_write) begin
                            r_awaddr  <= cmd_addr;
                            r_wdata   <= cmd_wdata;
                            r_wstrb   <= cmd_wstrb;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_bready  <= 1'b0;
                            r_state   <= WR;
                        end else begin
                            r_araddr  <= cmd_addr;
                            r_arvalid <= 1'b1;
                            r_state   <= RD;
                        end
                    end
                end
                WR: begin
                    if (w_aw_hs) r_awvalid <= 1'b0;
                    if (w_w_hs)  r_wvalid  <= 1'b0;
                    if (w_wr_done) begin
                        r_bready <= 1'b1;
                        r_state  <= WR_B;
                    end
                end
                WR_B: begin
                    if (m_axil.bvalid) begin
                        rsp_resp  <= m_axil.bresp;
                        rsp_rdata <= '0;
                        rsp_valid <= 1'b1;
                        r_state   <= RSP;
                    end
                end
                RD: begin
                    if (m_axil.arready) begin
                        r_arvalid <= 1'b0;
                        r_state   <= RD_R;
                    end
                end
                RD_R: begin
                    if (m_axil.rvalid) begin
                        rsp_rdata <= m_axil.rdata;
                        rsp_resp  <= m_axil.rresp;
                        rsp_valid <= 1'b1;
                        r_state   <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign m_axil.awaddr  = r_awaddr;
    assign m_axil.awprot  = PROT_DEFAULT;
    assign m_axil.awvalid = r_awvalid;
    assign m_axil.wdata   = r_wdata;
    assign m_axil.wstrb   = r_wstrb;
    assign m_axil.wvalid  = r_wvalid;
    assign m_axil.bready  = r_bready;
    assign m_axil.araddr  = r_araddr;
    assign m_axil.arprot  = PROT_DEFAULT;
    assign m_axil.arvalid = r_arvalid;
    // Read data is always accepted; stray beats outside RD_R are simply dropped.
    assign m_axil.rready  = 1'b1;

endmodule

`default_nettype wire

// File: tb/tb_axil_reg_master.sv
// ============================================================================
// Module      : tb_axil_reg_master
// Description : Directed bench with a latency-programmable AXI-Lite slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axil_reg_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [15:0] cmd_addr  = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    axil_reg_master_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

    axil_reg_master #(
        .AXI_ADDR_WIDTH (16),
        .AXI_DATA_WIDTH (32),
        .AXI_STRB_WIDTH (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .m_axi_clk   (clk),
        .m_axi_rst   (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_wstrb   (cmd_wstrb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_resp    (rsp_resp),
        .rsp_timeout (rsp_timeout),
        .m_axil      (bus)
    );

    // ---------------- slave model: ROM map plus one writable register at 0x4
    int          cfg_aw_lat = 0;
    int          cfg_w_lat  = 0;
    int          cfg_ar_lat = 0;
    int          inj_req    = 0;
    int          inj_ack;
    int          s_aw_cnt, s_w_cnt, s_ar_cnt;
    logic        s_aw_got, s_w_got, s_bvalid, s_rvalid;
    logic [15:0] s_awaddr;
    logic [31:0] s_wdata, s_rdata, s_reg4;
    logic [3:0]  s_wstrb;
    logic [1:0]  s_bresp, s_rresp;

    function automatic logic [31:0] rom_rd(input logic [15:0] a, input logic [31:0] r4);
        case (a)
            16'h0000: rom_rd = 32'h0005_0012;
            16'h0004: rom_rd = r4;
            16'h000C: rom_rd = 32'h0000_0002;
            16'h0010: rom_rd = 32'h0001_0001;
            default:  rom_rd = (a >= 16'h0020) ? 32'hDEC0_DE00 : 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m;
        m = o;
        for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = d[8*b +: 8];
        return m;
    endfunction

    assign bus.awready = bus.awvalid && !s_aw_got && (s_aw_cnt >= cfg_aw_lat);
    assign bus.wready  = bus.wvalid  && !s_w_got  && (s_w_cnt  >= cfg_w_lat);
    assign bus.arready = bus.arvalid && !s_rvalid && (s_ar_cnt >= cfg_ar_lat);
    assign bus.bvalid  = s_bvalid;
    assign bus.bresp   = s_bresp;
    assign bus.rvalid  = s_rvalid;
    assign bus.rdata   = s_rdata;
    assign bus.rresp   = s_rresp;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s_aw_cnt <= 0; s_w_cnt <= 0; s_ar_cnt <= 0;
            s_aw_got <= 1'b0; s_w_got <= 1'b0;
            s_bvalid <= 1'b0; s_rvalid <= 1'b0;
            s_bresp  <= 2'b00; s_rresp <= 2'b00;
            s_awaddr <= '0; s_wdata <= '0; s_wstrb <= '0; s_rdata <= '0;
            s_reg4   <= '0;
            inj_ack  <= inj_req;
        end else begin
            s_aw_cnt <= (bus.awvalid && !bus.awready) ? s_aw_cnt + 1 : 0;
            s_w_cnt  <= (bus.wvalid  && !bus.wready)  ? s_w_cnt  + 1 : 0;
            s_ar_cnt <= (bus.arvalid && !bus.arready) ? s_ar_cnt + 1 : 0;
            if (bus.awvalid && bus.awready) begin
                s_aw_got <= 1'b1;
                s_awaddr <= bus.awaddr;
            end
            if (bus.wvalid && bus.wready) begin
                s_w_got <= 1'b1;
                s_wdata <= bus.wdata;
                s_wstrb <= bus.wstrb;
            end
            if (s_bvalid && bus.bready) s_bvalid <= 1'b0;
            if (s_aw_got && s_w_got && !s_bvalid) begin
                s_bvalid <= 1'b1;
                s_bresp  <= (s_awaddr >= 16'h0020) ? 2'b11 : 2'b00;
                if (s_awaddr == 16'h0004) s_reg4 <= merge(s_reg4, s_wdata, s_wstrb);
                s_aw_got <= 1'b0;
                s_w_got  <= 1'b0;
            end
            if (s_rvalid && bus.rready) s_rvalid <= 1'b0;
            if (bus.arvalid && bus.arready) begin
                s_rvalid <= 1'b1;
                s_rdata  <= rom_rd(bus.araddr, s_reg4);
                s_rresp  <= (bus.araddr >= 16'h0020) ? 2'b11 : 2'b00;
            end else if (inj_req != inj_ack) begin
                s_rvalid <= 1'b1;
                s_rdata  <= 32'hBAD0_BAD0;
                s_rresp  <= 2'b00;
                inj_ack  <= inj_req;
            end
        end
    end

    // ---------------- bus activity monitor (free-running, sampled via deltas)
    int m_aw_high = 0, m_w_high = 0, m_ar_high = 0, m_ar_hs = 0, m_b_hs = 0;

    always @(posedge clk) begin
        if (!rst) begin
            if (bus.awvalid) m_aw_high <= m_aw_high + 1;
            if (bus.wvalid)  m_w_high  <= m_w_high + 1;
            if (bus.arvalid) m_ar_high <= m_ar_high + 1;
            if (bus.arvalid && bus.arready) m_ar_hs <= m_ar_hs + 1;
            if (bus.bvalid && bus.bready)   m_b_hs  <= m_b_hs + 1;
        end
    end

    // ---------------- helpers
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        cmd_valid = 1'b1;
        for (int n = 0; n < 50 && !cmd_ready; n++) @(negedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic collect(output logic ok, output logic [31:0] rd, output logic [1:0] rs, output logic to);
        for (int n = 0; n < 200 && !rsp_valid; n++) @(negedge clk);
        ok = rsp_valid; rd = rsp_rdata; rs = rsp_resp; to = rsp_timeout;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_lat;
        int          w_lat;
        int          ar_lat;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        logic        exp_tmo;
    } vec_t;

    vec_t vecs[13];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        ok, to;
        logic [31:0] rd, d0;
        logic [1:0]  rs;
        int          aw0, w0, ar0, arh0, b0, acc;
        logic        flag;

        vecs[0]  = '{1'b0, 16'h0000, 32'h0,         4'h0, 0, 0, 0,  32'h0005_0012, 2'b00, 1'b0};
        vecs[1]  = '{1'b0, 16'h0010, 32'h0,         4'h0, 0, 0, 0,  32'h0001_0001, 2'b00, 1'b0};
        vecs[2]  = '{1'b0, 16'h000C, 32'h0,         4'h0, 0, 0, 1,  32'h0000_0002, 2'b00, 1'b0};
        vecs[3]  = '{1'b1, 16'h0004, 32'hDEADBEEF,  4'hF, 0, 3, 0,  32'h0,         2'b00, 1'b0};
        vecs[4]  = '{1'b0, 16'h0004, 32'h0,         4'h0, 0, 0, 0,  32'hDEAD_BEEF, 2'b00, 1'b0};
        vecs[5]  = '{1'b1, 16'h0004, 32'h11223344,  4'h5, 1, 1, 0,  32'h0,         2'b00, 1'b0};
        vecs[6]  = '{1'b0, 16'h0004, 32'h0,         4'h0, 0, 0, 2,  32'hDE22_BE44, 2'b00, 1'b0};
        vecs[7]  = '{1'b1, 16'h0008, 32'hFFFFFFFF,  4'hF, 4, 0, 0,  32'h0,         2'b00, 1'b0};
        vecs[8]  = '{1'b0, 16'h0008, 32'h0,         4'h0, 0, 0, 0,  32'h0,         2'b00, 1'b0};
        vecs[9]  = '{1'b0, 16'h0024, 32'h0,         4'h0, 0, 0, 0,  32'hDEC0_DE00, 2'b11, 1'b0};
        vecs[10] = '{1'b1, 16'h0030, 32'h12345678,  4'hF, 0, 0, 0,  32'h0,         2'b11, 1'b0};
        vecs[11] = '{1'b0, 16'h0000, 32'h0,         4'h0, 0, 0, 15, 32'h0005_0012, 2'b00, 1'b0};
        vecs[12] = '{1'b0, 16'h0000, 32'h0,         4'h0, 0, 0, 16, 32'h0,         2'b10, 1'b1};

        // reset values
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready",   {31'd0, cmd_ready},   32'd1);
        chk("rst_valids",      {29'd0, bus.awvalid, bus.wvalid, bus.arvalid}, 32'd0);
        chk("rst_readies",     {30'd0, bus.bready, bus.rready}, 32'd3);
        chk("rst_addr",        {bus.awaddr, bus.araddr}, 32'd0);
        chk("rst_wdata",       bus.wdata, 32'd0);
        chk("rst_prot",        {26'd0, bus.awprot, bus.arprot}, 32'd0);
        chk("rst_rsp",         {28'd0, rsp_valid, rsp_resp, rsp_timeout}, 32'd0);
        chk("rst_rsp_rdata",   rsp_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // table-driven transactions
        for (int i = 0; i < 13; i++) begin
            cfg_aw_lat = vecs[i].aw_lat;
            cfg_w_lat  = vecs[i].w_lat;
            cfg_ar_lat = vecs[i].ar_lat;
            aw0 = m_aw_high; w0 = m_w_high; ar0 = m_ar_high; arh0 = m_ar_hs; b0 = m_b_hs;
            issue(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
            collect(ok, rd, rs, to);
            chk($sformatf("v%0d_rsp_seen", i), {31'd0, ok}, 32'd1);
            chk($sformatf("v%0d_rdata", i),   rd, vecs[i].exp_rdata);
            chk($sformatf("v%0d_resp", i),    {30'd0, rs}, {30'd0, vecs[i].exp_resp});
            chk($sformatf("v%0d_timeout", i), {31'd0, to}, {31'd0, vecs[i].exp_tmo});
            if (vecs[i].wr) begin
                chk($sformatf("v%0d_aw_cycles", i), m_aw_high - aw0, vecs[i].aw_lat + 1);
                chk($sformatf("v%0d_w_cycles", i),  m_w_high - w0,   vecs[i].w_lat + 1);
                chk($sformatf("v%0d_b_count", i),   m_b_hs - b0,     32'd1);
            end else begin
                chk($sformatf("v%0d_ar_cycles", i), m_ar_high - ar0,
                    vecs[i].exp_tmo ? 32'd16 : vecs[i].ar_lat + 1);
                chk($sformatf("v%0d_ar_count", i),  m_ar_hs - arh0,
                    vecs[i].exp_tmo ? 32'd0 : 32'd1);
            end
        end
        cfg_ar_lat = 0;

        // stray read beat in IDLE after the timeout
        chk("stray_pre_tmo", {31'd0, rsp_timeout}, 32'd1);
        inj_req = inj_req + 1;
        flag = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            flag = flag | rsp_valid;
        end
        chk("stray_no_rsp",    {31'd0, flag}, 32'd0);
        chk("stray_consumed",  {31'd0, bus.rvalid}, 32'd0);
        chk("stray_rdata_hold", rsp_rdata, 32'd0);
        chk("stray_resp_hold", {30'd0, rsp_resp}, 32'd2);
        issue(1'b0, 16'h0000, 32'h0, 4'h0);
        chk("tmo_clear_on_accept", {31'd0, rsp_timeout}, 32'd0);
        collect(ok, rd, rs, to);
        chk("post_stray_rdata", rd, 32'h0005_0012);

        // response backpressure with the next command already pending
        issue(1'b0, 16'h0010, 32'h0, 4'h0);
        for (int n = 0; n < 50 && !rsp_valid; n++) @(negedge clk);
        d0 = rsp_rdata;
        cmd_write = 1'b0; cmd_addr = 16'h000C; cmd_valid = 1'b1;
        flag = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            flag = flag & rsp_valid & (rsp_rdata == d0) & !cmd_ready;
        end
        chk("bp_stable", {31'd0, flag}, 32'd1);
        chk("bp_rdata",  d0, 32'h0001_0001);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp_ready_after", {30'd0, cmd_ready, rsp_valid}, 32'd2);
        @(negedge clk);
        chk("bp_next_accepted", {30'd0, cmd_ready, bus.arvalid}, 32'd1);
        cmd_valid = 1'b0;
        collect(ok, rd, rs, to);
        chk("bp_next_rdata", rd, 32'h0000_0002);

        // zero-wait reads back to back: one accept every 4 cycles
        cmd_write = 1'b0; cmd_addr = 16'h0000; cmd_valid = 1'b1; rsp_ready = 1'b1;
        acc = 0;
        for (int k = 0; k < 12; k++) begin
            if (cmd_ready) acc++;
            @(negedge clk);
        end
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        chk("b2b_accepts", acc, 32'd3);

        // asynchronous reset in the middle of a write
        cfg_aw_lat = 10; cfg_w_lat = 10;
        issue(1'b1, 16'h0004, 32'h12345678, 4'hF);
        chk("mid_awvalid", {31'd0, bus.awvalid}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_valids", {30'd0, bus.awvalid, bus.wvalid}, 32'd0);
        chk("mid_rst_idle",   {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        cfg_aw_lat = 0; cfg_w_lat = 0;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
        issue(1'b0, 16'h0000, 32'h0, 4'h0);
        collect(ok, rd, rs, to);
        chk("post_rst_read", {ok, 29'd0, rs}, {1'b1, 31'd0});
        chk("post_rst_rdata", rd, 32'h0005_0012);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axil_reg_master.md
Name: axil_reg_master

Overview:
- AXI4-Lite initiator that turns a simple command/response handshake into single AXI-Lite register reads and writes.
- Sits on the user/test side and drives AXI-Lite register targets such as the DMA system-information ROM and the channel register files.
- Only one transaction is outstanding at a time.
- A programmable timeout ensures the command side never hangs on a non-responding target.

Parameters:
- AXI_ADDR_WIDTH, 16, AXI-Lite address width.
- AXI_DATA_WIDTH, 32, AXI-Lite data width.
- AXI_STRB_WIDTH, AXI_DATA_WIDTH/8, write strobe width.
- TIMEOUT_CYCLES, 1024, bus-phase cycle limit per transaction; 0 disables the timeout.

Ports:
- m_axi_clk  in  1  single clock for all interfaces.
- m_axi_rst  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  AXI_ADDR_WIDTH  byte address.
- cmd_wdata  in  AXI_DATA_WIDTH  write data.
- cmd_wstrb  in  AXI_STRB_WIDTH  write strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  AXI_DATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_resp  out  2  AXI response code.
- rsp_timeout  out  1  transaction aborted by timeout.
- m_axil_awaddr/awprot/awvalid/awready, m_axil_wdata/wstrb/wvalid/wready, m_axil_bresp/bvalid/bready, m_axil_araddr/arprot/arvalid/arready, m_axil_rdata/rresp/rvalid/rready: standard AXI-Lite master channel signals.
  - Widths follow the parameters.
  - Direction is the mirror of a slave.

Behaviour:
- Reset (asynchronous, m_axi_rst=1):
  - State = IDLE.
  - All AXI valids = 0; awaddr/araddr/wdata/wstrb = 0.
  - bready = rready = 1.
  - rsp_valid = 0, rsp_rdata = 0, rsp_resp = 0, rsp_timeout = 0.
  - Timeout counter = 0.
- awprot/arprot are constant 3'b000.
- cmd_ready = (state == IDLE); it is combinational from state.
- FSM states: IDLE, WR, WR_B, RD, RD_R, RSP.
- IDLE:
  - On cmd_valid, latch addr/wdata/wstrb.
  - cmd_write=1 -> WR; cmd_write=0 -> RD.
  - AXI valids assert on the next cycle (accept at cycle N, valid at N+1).
- WR:
  - awvalid and wvalid assert together.
  - Each deasserts independently on its own handshake (awvalid&awready, wvalid&wready); either order, or the same cycle, is legal.
  - When both are done -> WR_B.
  - bready is 0 in WR.
- WR_B:
  - bready = 1.
  - On bvalid: capture bresp into rsp_resp, rsp_rdata = 0 -> RSP.
- RD:
  - arvalid = 1 until arready -> RD_R.
  - araddr is stable while arvalid is high.
- RD_R:
  - rready = 1.
  - On rvalid: capture rdata and rresp -> RSP.
- RSP:
  - rsp_valid = 1; response fields are held stable until rsp_ready, then -> IDLE.
  - rsp_valid is 1 for at least one cycle.
- Valid stability: AXI valids never drop before their handshake, except on timeout abort.
- Timeout:
  - The counter clears on entry to WR or RD and increments every cycle in WR, WR_B, RD, RD_R.
  - When it equals TIMEOUT_CYCLES (TIMEOUT_CYCLES != 0): all AXI valids drop, rsp_resp = 2'b10 (SLVERR), rsp_timeout = 1, rsp_rdata = 0 -> RSP.
  - If a handshake and the timeout hit in the same cycle, the handshake wins and the timeout is ignored.
- Stray responses: in IDLE and RSP, bready = rready = 1. A late bvalid/rvalid is consumed and discarded and does not alter rsp_* fields.
- rsp_timeout clears when the next command is accepted.
- Back-to-back commands: the earliest a new command can be accepted is the cycle after rsp_valid&rsp_ready. This gives a minimum cycle count of 4 per zero-wait read.
- Reset mid-transaction: everything returns immediately to reset values and any in-flight AXI transaction is abandoned. Targets are reset by the same reset.

Decomposition:
- Package axil_master_pkg holds:
  - state enum (IDLE, WR, WR_B, RD, RD_R, RSP);
  - AXI response constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - PROT_DEFAULT=3'b000.
- One sub-module, axil_timeout_cnt:
  - inputs: clear, enable;
  - output: expired;
  - parameter TIMEOUT_CYCLES;
  - counter width $clog2(TIMEOUT_CYCLES+1).

Test Plan:
- Version read: master wired to the system ROM slave (VER_MJ=0x0005, VER_MN=0x0012); read addr 0x0 -> rsp_rdata=0x00050012, rsp_resp=0, rsp_timeout=0, arvalid high exactly until arready.
- Channel-count read: ROM with 1 C2S, 1 S2C; read addr 0x10 -> rsp_rdata=0x00010001; read addr 0xC -> 0x00000002.
- Write with skewed readies: write addr 0x4, data 0xDEADBEEF, strb 0xF. The BFM slave asserts wready 3 cycles after awready -> awvalid drops first and wvalid stays until its own handshake; exactly one B accepted; bresp=0 returned once.
- Timeout: TIMEOUT_CYCLES=16, slave never asserts arready -> arvalid drops after 16 cycles in RD, rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0. A late rvalid injected in IDLE is consumed with no new rsp_valid.
- Backpressure: rsp_ready held 0 for 5 cycles after a read -> rsp_valid and rsp_rdata stable for all 5 cycles, cmd_ready=0 throughout, next command accepted the cycle after rsp_ready.
- Reset mid-write: assert m_axi_rst while awvalid=1 -> awvalid/wvalid go to 0 without waiting for a clock edge, state IDLE, cmd_ready=1 after release, and a subsequent read completes normally.
